// File: rtl/program_feeder.sv
// Purpose : holds a loadable program and feeds instruction/immediate words to a
//           16-bit multicycle processor on DIN.
// Latency : Start -> first FETCH in 1 clock. DIN is combinational from mem[Pc] and state.
//           Run cycles: mv 2, mvi 2, ALU op 4 (FETCH + 3 EXEC).
// Backpressure: the processor's Done paces the sequencer, and EXEC waits for Done.
//               Done in FETCH, or no Done in IMM, raises Err and halts.
//               Memory writes are accepted only in IDLE/HALT and dropped otherwise.
//
// Ports   : Clock/Resetn (async active-low); Start/EndAddr launch a program at address 0;
//           WrEn/WrAddr/WrData load program memory; DIN/Run/Done form the processor link;
//           Busy/ProgDone/Pc/Err report status.
// Option  : PROGRAM_FEEDER_WATCHDOG_EN -- if Done is missing by the 3rd EXEC cycle,
//           flag Err and halt.
module program_feeder #(
  parameter int AW = 5,
  parameter int W  = 16
) (
  input  logic          Clock,
  input  logic          Resetn,
  input  logic          Start,
  input  logic [AW-1:0] EndAddr,
  input  logic          WrEn,
  input  logic [AW-1:0] WrAddr,
  input  logic [W-1:0]  WrData,
  output logic [W-1:0]  DIN,
  output logic          Run,
  input  logic          Done,
  output logic          Busy,
  output logic          ProgDone,
  output logic [AW-1:0] Pc,
  output logic          Err
);

  localparam logic [2:0] OP_MVI = 3'b001;

  typedef enum logic [2:0] {
    S_IDLE,
    S_FETCH,
    S_IMM,
    S_EXEC,
    S_HALT
  } state_t;

  state_t        state, state_nxt;
  logic [AW-1:0] pc_nxt;
  logic [AW-1:0] end_addr, end_addr_nxt;
  logic          err_nxt;
  logic          end_seen, end_seen_nxt;
  logic          idle_like;
  logic [W-1:0]  cur_word;

  // Program memory is deliberately not reset, so a program survives Resetn.
  logic [W-1:0]  mem [0:(2**AW)-1];

`ifdef PROGRAM_FEEDER_WATCHDOG_EN
  logic [1:0]    wd_cnt, wd_cnt_nxt;
`endif

  assign idle_like = (state == S_IDLE) || (state == S_HALT);
  assign Busy      = (state == S_FETCH) || (state == S_IMM) || (state == S_EXEC);
  assign Run       = Busy;
  assign cur_word  = mem[Pc];
  assign DIN       = Busy ? cur_word : '0;
  assign ProgDone  = (state == S_HALT) && !Err;

  always_ff @(posedge Clock) begin
    if (WrEn && idle_like) begin
      mem[WrAddr] <= WrData;
    end
  end

  always_ff @(posedge Clock or negedge Resetn) begin
    if (!Resetn) begin
      state    <= S_IDLE;
      Pc       <= '0;
      Err      <= 1'b0;
      end_seen <= 1'b0;
      end_addr <= '0;
`ifdef PROGRAM_FEEDER_WATCHDOG_EN
      wd_cnt   <= 2'd0;
`endif
    end else begin
      state    <= state_nxt;
      Pc       <= pc_nxt;
      Err      <= err_nxt;
      end_seen <= end_seen_nxt;
      end_addr <= end_addr_nxt;
`ifdef PROGRAM_FEEDER_WATCHDOG_EN
      wd_cnt   <= wd_cnt_nxt;
`endif
    end
  end

  always_comb begin
    state_nxt    = state;
    pc_nxt       = Pc;
    err_nxt      = Err;
    end_seen_nxt = end_seen;
    end_addr_nxt = end_addr;
`ifdef PROGRAM_FEEDER_WATCHDOG_EN
    wd_cnt_nxt   = wd_cnt;
`endif
    case (state)
      S_IDLE, S_HALT: begin
        if (Start) begin
          state_nxt    = S_FETCH;
          pc_nxt       = '0;
          err_nxt      = 1'b0;
          end_seen_nxt = 1'b0;
          end_addr_nxt = EndAddr;
        end
      end
      S_FETCH: begin
        if (Done) begin
          // The processor cannot have finished an instruction it has not seen yet.
          err_nxt   = 1'b1;
          state_nxt = S_HALT;
        end else begin
          pc_nxt = Pc + 1'b1;
          if (Pc == end_addr) begin
            end_seen_nxt = 1'b1;
          end
          state_nxt = (cur_word[8:6] == OP_MVI) ? S_IMM : S_EXEC;
`ifdef PROGRAM_FEEDER_WATCHDOG_EN
          wd_cnt_nxt = 2'd0;
`endif
        end
      end
      S_IMM: begin
        if (Done) begin
          pc_nxt = Pc + 1'b1;
          // Include this cycle's match so an immediate at EndAddr terminates.
          if (end_seen || (Pc == end_addr)) begin
            end_seen_nxt = 1'b1;
            state_nxt    = S_HALT;
          end else begin
            state_nxt = S_FETCH;
          end
        end else begin
          err_nxt   = 1'b1;
          state_nxt = S_HALT;
        end
      end
      S_EXEC: begin
        if (Done) begin
          state_nxt = end_seen ? S_HALT : S_FETCH;
        end else begin
`ifdef PROGRAM_FEEDER_WATCHDOG_EN
          if (wd_cnt == 2'd2) begin
            err_nxt   = 1'b1;
            state_nxt = S_HALT;
          end else begin
            wd_cnt_nxt = wd_cnt + 2'd1;
          end
`endif
        end
      end
      default: state_nxt = S_IDLE;
    endcase
  end

endmodule
